// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_pkg
//  Description : Shared video-pipeline types and 640x480@60 timing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package vpu_pkg;

    // Streamer FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_IDLE      = 2'd0;
    localparam state_t c_WAIT_FILL = 2'd1;
    localparam state_t c_RUN       = 2'd2;

    // 640x480 timing, in pixel clocks / lines
    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    // RGB888 pixel, packed {R, G, B} to match the FIFO word layout
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Free-running h/v raster counters with active and sync decode.
//                Counters advance only while run is high, otherwise sit at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hsync_pre,
    output logic       vsync_pre
);

    localparam logic [9:0] c_H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] c_HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] c_VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] c_V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // Raster counters: h wraps each line, v steps on h wrap and wraps per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == c_H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == c_V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign active    = (h_cnt < c_H_ACT) && (v_cnt < c_V_ACT);
    assign hsync_pre = !((h_cnt >= c_HS_BEG) && (h_cnt < c_HS_END));
    assign vsync_pre = !((v_cnt >= c_VS_BEG) && (v_cnt < c_VS_END));

endmodule
`default_nettype wire

// File: rtl/bg_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : bg_pixel_streamer
//  Description : Streams background pixels from a FIFO onto a VGA-style raster
//                with a 2-clock sync/pixel pipeline and sticky underflow flag.
//                Define VPU_UNDERFLOW_CNT_EN to add a saturating 16-bit
//                underflow_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bg_pixel_streamer
    import vpu_pkg::*;
#(
    parameter int          H_ACTIVE        = c_H_ACTIVE,
    parameter int          H_FP            = c_H_FP,
    parameter int          H_SYNC          = c_H_SYNC,
    parameter int          H_BP            = c_H_BP,
    parameter int          V_ACTIVE        = c_V_ACTIVE,
    parameter int          V_FP            = c_V_FP,
    parameter int          V_SYNC          = c_V_SYNC,
    parameter int          V_BP            = c_V_BP,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_q,
    output logic        fifo_rd_en,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_start,
    output logic        underflow
`ifdef VPU_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_count
`endif
);

    localparam logic [9:0] c_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    state_t     r_state;
    logic       w_run;
    logic [9:0] w_h_cnt;
    logic [9:0] w_v_cnt;
    logic       w_active;
    logic       w_hsync_pre;
    logic       w_vsync_pre;
    logic       w_frame_wrap;
    logic       w_origin;

    logic       r_s1_active;
    logic       r_s1_pop;
    logic       r_s1_hsync;
    logic       r_s1_vsync;
    logic       r_s1_origin;

    rgb_t       w_q;
    rgb_t       w_pix;
    logic       w_uf_pix;

    assign w_run        = (r_state == c_RUN);
    assign w_frame_wrap = (w_h_cnt == c_H_LAST) && (w_v_cnt == c_V_LAST);
    assign w_origin     = (w_h_cnt == 10'd0) && (w_v_cnt == 10'd0);
    assign w_q          = rgb_t'(fifo_q);

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .run       (w_run),
        .h_cnt     (w_h_cnt),
        .v_cnt     (w_v_cnt),
        .active    (w_active),
        .hsync_pre (w_hsync_pre),
        .vsync_pre (w_vsync_pre)
    );

    // Control FSM: wait for first FIFO data, and only stop on a frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (enable) r_state <= c_WAIT_FILL;
                end
                c_WAIT_FILL: begin
                    if (!enable)         r_state <= c_IDLE;
                    else if (!fifo_empty) r_state <= c_RUN;
                end
                c_RUN: begin
                    if (w_frame_wrap && !enable) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Pop only for visible pixels; an empty FIFO drops the pixel, never stalls
    assign fifo_rd_en = w_run && w_active && !fifo_empty;

    // Stage 1: align position-derived flags with the FIFO read-data latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_active <= 1'b0;
            r_s1_pop    <= 1'b0;
            r_s1_hsync  <= 1'b1;
            r_s1_vsync  <= 1'b1;
            r_s1_origin <= 1'b0;
        end else begin
            r_s1_active <= w_run && w_active;
            r_s1_pop    <= fifo_rd_en;
            r_s1_hsync  <= !w_run || w_hsync_pre;
            r_s1_vsync  <= !w_run || w_vsync_pre;
            r_s1_origin <= w_run && w_origin;
        end
    end

    // Pixel select: FIFO data if popped, underflow colour if dropped, else black
    always_comb begin
        w_pix = '0;
        if (r_s1_active) begin
            w_pix = r_s1_pop ? w_q : rgb_t'(UNDERFLOW_COLOR);
        end
    end

    assign w_uf_pix = r_s1_active && !r_s1_pop;

    // Stage 2: register every output; underflow is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            hsync       <= r_s1_hsync;
            vsync       <= r_s1_vsync;
            blank_n     <= r_s1_active;
            r           <= w_pix.r;
            g           <= w_pix.g;
            b           <= w_pix.b;
            frame_start <= r_s1_origin;
            underflow   <= underflow || w_uf_pix;
        end
    end

`ifdef VPU_UNDERFLOW_CNT_EN
    logic [15:0] r_uf_cnt;

    // Count dropped pixels, saturating rather than wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_uf_cnt <= '0;
        end else if (w_uf_pix && (r_uf_cnt != 16'hFFFF)) begin
            r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end

    assign underflow_count = r_uf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bg_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bg_pixel_streamer
//  Description : Directed self-checking bench for bg_pixel_streamer using a
//                reduced raster (160x14 total, 128x8 visible) so whole frames
//                run quickly. Honours VPU_UNDERFLOW_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_pixel_streamer;
    import vpu_pkg::*;

    localparam int HA = 128, HF = 8, HS = 16, HB = 8, HT = HA + HF + HS + HB;
    localparam int VA = 8, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [23:0] fifo_q;
    logic        fifo_rd_en;
    logic        hsync, vsync, blank_n;
    logic [7:0]  r, g, b;
    logic        frame_start;
    logic        underflow;
`ifdef VPU_UNDERFLOW_CNT_EN
    logic [15:0] underflow_count;
`endif

    logic        empty_all;
    logic        gap_en;
    logic [23:0] fifo_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bg_pixel_streamer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .UNDERFLOW_COLOR (24'hFF00FF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_q      (fifo_q),
        .fifo_rd_en  (fifo_rd_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .r           (r),
        .g           (g),
        .b           (b),
        .frame_start (frame_start),
        .underflow   (underflow)
`ifdef VPU_UNDERFLOW_CNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    // FIFO model: empty everywhere or only over pixels 100..109 of line 5
    assign fifo_empty = empty_all | (gap_en & (dut.w_v_cnt == 10'd5) &
                        (dut.w_h_cnt >= 10'd100) & (dut.w_h_cnt <= 10'd109));

    // FIFO read data appears one clock after the pop
    always @(posedge clk or posedge reset) begin
        if (reset)           fifo_q <= 24'h0;
        else if (fifo_rd_en) fifo_q <= fifo_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; empty_all = 1'b1; gap_en = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_fs(input int budget, output int waited, output bit seen);
        seen = 1'b0; waited = budget;
        for (int i = 0; i < budget; i++) begin
            if (frame_start === 1'b1) begin
                seen = 1'b1; waited = i;
                break;
            end
            step();
        end
    endtask

    // Observe one frame starting at a frame_start sample, scoring against the raster model
    task automatic observe_frame(input bit gap, input logic [23:0] data, input int drop_at,
                                 output int pix_err, output int sync_err, output int pops,
                                 output int hs_pulses, output int vs_low, output int vs_pulses,
                                 output bit uf99, output bit uf100, output bit fs_next);
        int h, v;
        bit act, exp_hs, exp_vs, exp_fs, prev_hs, prev_vs;
        logic [23:0] exp_rgb;
        pix_err = 0; sync_err = 0; pops = 0; hs_pulses = 0; vs_low = 0; vs_pulses = 0;
        uf99 = 1'b0; uf100 = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            h = k % HT; v = k / HT;
            act = (h < HA) && (v < VA);
            if (!act) exp_rgb = 24'h0;
            else if (gap && v == 5 && h >= 100 && h <= 109) exp_rgb = 24'hFF00FF;
            else exp_rgb = data;
            exp_hs = !((h >= HA + HF) && (h < HA + HF + HS));
            exp_vs = !((v >= VA + VF) && (v < VA + VF + VS));
            exp_fs = (k == 0);
            if ({r, g, b} !== exp_rgb || blank_n !== act) pix_err++;
            if (hsync !== exp_hs || vsync !== exp_vs || frame_start !== exp_fs) sync_err++;
            if (fifo_rd_en === 1'b1) pops++;
            if (prev_hs && hsync === 1'b0) hs_pulses++;
            if (prev_vs && vsync === 1'b0) vs_pulses++;
            if (vsync === 1'b0) vs_low++;
            if (k == 5 * HT + 99)  uf99  = underflow;
            if (k == 5 * HT + 100) uf100 = underflow;
            prev_hs = (hsync === 1'b1);
            prev_vs = (vsync === 1'b1);
            if (k == drop_at) enable = 1'b0;
            step();
        end
        fs_next = frame_start;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; empty_all = 1'b1; gap_en = 1'b0; fifo_data = 24'h0;
        step(); step();
        checks++;
        if ({hsync, vsync, blank_n, frame_start, underflow, fifo_rd_en} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 110000", {hsync, vsync, blank_n, frame_start, underflow, fifo_rd_en});
        end
        checks++;
        if ({r, g, b} !== 24'h0) begin
            errors++; $display("FAIL reset_rgb: got %h want 000000", {r, g, b});
        end
        checks++;
        if (dut.r_state !== c_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, c_IDLE);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_wait_fill();
        int bad = 0;
        enable = 1'b1; empty_all = 1'b1;
        step();
        for (int i = 0; i < 1000; i++) begin
            if (dut.r_state !== c_WAIT_FILL || fifo_rd_en !== 1'b0 || hsync !== 1'b1 || blank_n !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL wait_fill_hold: got %0d bad cycles want 0", bad);
        end
        enable = 1'b0;
        step();
        checks++;
        if (dut.r_state !== c_IDLE) begin
            errors++; $display("FAIL wait_fill_exit: got state %0d want %0d", dut.r_state, c_IDLE);
        end
    endtask

    task automatic test_first_frame();
        int waited, blank_len, hs_fall, hs_low, next_rise;
        bit seen, prev_b, prev_h;
        do_reset();
        fifo_data = 24'h112233; empty_all = 1'b0; enable = 1'b1;
        wait_fs(50, waited, seen);
        checks++;
        if (!seen || waited !== 4) begin
            errors++; $display("FAIL start_latency: got %0d clocks (seen=%0d) want 4", waited, seen);
        end
        checks++;
        if ({r, g, b} !== 24'h112233 || blank_n !== 1'b1) begin
            errors++; $display("FAIL first_pixel: got %h blank_n=%b want 112233 blank_n=1", {r, g, b}, blank_n);
        end
        blank_len = 0; hs_fall = -1; hs_low = 0; next_rise = -1; prev_b = 1'b1; prev_h = 1'b1;
        for (int k = 0; k < 2 * HT; k++) begin
            if (k < HT && blank_n === 1'b1) blank_len++;
            if (hs_fall < 0 && prev_h && hsync === 1'b0) hs_fall = k;
            if (k < HT && hsync === 1'b0) hs_low++;
            if (next_rise < 0 && k > 0 && !prev_b && blank_n === 1'b1) next_rise = k;
            prev_b = (blank_n === 1'b1);
            prev_h = (hsync === 1'b1);
            step();
        end
        checks++;
        if (blank_len !== HA) begin
            errors++; $display("FAIL blank_width: got %0d want %0d", blank_len, HA);
        end
        checks++;
        if (hs_fall !== HA + HF) begin
            errors++; $display("FAIL hsync_offset: got %0d want %0d", hs_fall, HA + HF);
        end
        checks++;
        if (hs_low !== HS) begin
            errors++; $display("FAIL hsync_width: got %0d want %0d", hs_low, HS);
        end
        checks++;
        if (next_rise !== HT) begin
            errors++; $display("FAIL line_period: got %0d want %0d", next_rise, HT);
        end
    endtask

    task automatic test_full_frame();
        int waited, pix_err, sync_err, pops, hs_p, vs_low, vs_p;
        bit seen, uf99, uf100, fs_next;
        do_reset();
        fifo_data = 24'hA5C3E7; empty_all = 1'b0; enable = 1'b1;
        wait_fs(50, waited, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL full_start: got no frame_start want frame_start");
        end
        observe_frame(1'b0, 24'hA5C3E7, -1, pix_err, sync_err, pops, hs_p, vs_low, vs_p, uf99, uf100, fs_next);
        checks++;
        if (pix_err !== 0) begin errors++; $display("FAIL full_pixels: got %0d bad want 0", pix_err); end
        checks++;
        if (sync_err !== 0) begin errors++; $display("FAIL full_sync: got %0d bad want 0", sync_err); end
        checks++;
        if (pops !== HA * VA) begin errors++; $display("FAIL full_pops: got %0d want %0d", pops, HA * VA); end
        checks++;
        if (hs_p !== VT) begin errors++; $display("FAIL full_hsync_pulses: got %0d want %0d", hs_p, VT); end
        checks++;
        if (vs_p !== 1 || vs_low !== VS * HT) begin
            errors++; $display("FAIL full_vsync: got %0d pulses %0d low want 1 pulse %0d low", vs_p, vs_low, VS * HT);
        end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL full_underflow: got %b want 0", underflow); end
        checks++;
        if (fs_next !== 1'b1) begin errors++; $display("FAIL full_period: got frame_start=%b want 1", fs_next); end
    endtask

    task automatic test_underflow_gap();
        int waited, pix_err, sync_err, pops, hs_p, vs_low, vs_p;
        bit seen, uf99, uf100, fs_next;
        do_reset();
        fifo_data = 24'h3C5A7E; empty_all = 1'b0; gap_en = 1'b1; enable = 1'b1;
        wait_fs(50, waited, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL gap_start: got no frame_start want frame_start"); end
        observe_frame(1'b1, 24'h3C5A7E, -1, pix_err, sync_err, pops, hs_p, vs_low, vs_p, uf99, uf100, fs_next);
        checks++;
        if (pix_err !== 0) begin errors++; $display("FAIL gap_pixels: got %0d bad want 0", pix_err); end
        checks++;
        if (pops !== HA * VA - 10) begin errors++; $display("FAIL gap_pops: got %0d want %0d", pops, HA * VA - 10); end
        checks++;
        if (sync_err !== 0 || fs_next !== 1'b1) begin
            errors++; $display("FAIL gap_timing: got %0d sync errors fs_next=%b want 0 and 1", sync_err, fs_next);
        end
        checks++;
        if (uf99 !== 1'b0 || uf100 !== 1'b1 || underflow !== 1'b1) begin
            errors++; $display("FAIL gap_underflow: got %b%b%b want 011", uf99, uf100, underflow);
        end
`ifdef VPU_UNDERFLOW_CNT_EN
        checks++;
        if (underflow_count !== 16'd10) begin
            errors++; $display("FAIL gap_count: got %0d want 10", underflow_count);
        end
`endif
        gap_en = 1'b0;
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 50; i++) step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({hsync, vsync, blank_n, frame_start, underflow, fifo_rd_en} !== 6'b110000 || {r, g, b} !== 24'h0) begin
            errors++;
            $display("FAIL midline_reset: got %b rgb %h want 110000 rgb 000000",
                     {hsync, vsync, blank_n, frame_start, underflow, fifo_rd_en}, {r, g, b});
        end
        checks++;
        if (dut.r_state !== c_IDLE || dut.w_h_cnt !== 10'd0) begin
            errors++; $display("FAIL midline_state: got state %0d h %0d want 0 0", dut.r_state, dut.w_h_cnt);
        end
`ifdef VPU_UNDERFLOW_CNT_EN
        checks++;
        if (underflow_count !== 16'd0) begin
            errors++; $display("FAIL midline_count: got %0d want 0", underflow_count);
        end
`endif
        reset = 1'b0;
        step();
        checks++;
        if (dut.r_state !== c_WAIT_FILL) begin
            errors++; $display("FAIL midline_refill: got state %0d want %0d", dut.r_state, c_WAIT_FILL);
        end
    endtask

    task automatic test_enable_drop();
        int waited, pix_err, sync_err, pops, hs_p, vs_low, vs_p, bad;
        bit seen, uf99, uf100, fs_next;
        do_reset();
        fifo_data = 24'h5A6B7C; empty_all = 1'b0; enable = 1'b1;
        wait_fs(50, waited, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL drop_start: got no frame_start want frame_start"); end
        observe_frame(1'b0, 24'h5A6B7C, 4 * HT, pix_err, sync_err, pops, hs_p, vs_low, vs_p, uf99, uf100, fs_next);
        checks++;
        if (pix_err !== 0 || sync_err !== 0 || vs_low !== VS * HT) begin
            errors++; $display("FAIL drop_frame_complete: got pix %0d sync %0d vs_low %0d want 0 0 %0d", pix_err, sync_err, vs_low, VS * HT);
        end
        checks++;
        if (pops !== HA * VA - 2) begin errors++; $display("FAIL drop_pops: got %0d want %0d", pops, HA * VA - 2); end
        checks++;
        if (fs_next !== 1'b0 || dut.r_state !== c_IDLE) begin
            errors++; $display("FAIL drop_idle: got fs=%b state %0d want 0 %0d", fs_next, dut.r_state, c_IDLE);
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (hsync !== 1'b1 || vsync !== 1'b1 || blank_n !== 1'b0 || {r, g, b} !== 24'h0 ||
                fifo_rd_en !== 1'b0 || frame_start !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL drop_idle_outputs: got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_wait_fill();
        test_first_frame();
        test_full_frame();
        test_underflow_gap();
        test_reset_midline();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bg_pixel_streamer.md
BG_PIXEL_STREAMER -- requirements
Module: bg_pixel_streamer

Interface
REQ-001 The block SHALL declare these parameters: H_ACTIVE, default 640, visible pixels per line.
REQ-002 H_FP, default 16, horizontal front porch in clocks.
REQ-003 H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 H_BP, default 48, horizontal back porch in clocks.
REQ-005 V_ACTIVE, default 480, visible lines; V_FP, default 10; V_SYNC, default 2; V_BP, default 33.
REQ-006 UNDERFLOW_COLOR, default 24'hFF00FF, RGB driven for an active pixel with no FIFO data.
REQ-007 The block SHALL have the following ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  requests streaming.
- fifo_empty  in  1  background FIFO empty flag.
- fifo_q  in  24  background FIFO read data {RR,GG,BB}; valid one clock after fifo_rd_en.
- fifo_rd_en  out  1  background FIFO pop.
- hsync  out  1  active-low.
- vsync  out  1  active-low.
- blank_n  out  1  high during visible pixels.
- r, g, b  out  8 each  pixel colour.
- frame_start  out  1  one-clock pulse at output pixel (0,0).
- underflow  out  1  sticky underflow flag.

Function
REQ-008 The block SHALL contain free-running counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), both 10 bits wide.
- H_TOTAL = sum of the H_* parameters = 800.
- V_TOTAL = sum of the V_* parameters = 525.
- v_cnt SHALL increment when h_cnt wraps, and SHALL itself wrap after V_TOTAL-1.
REQ-009 The FSM SHALL use states IDLE, WAIT_FILL and RUN. The counters SHALL advance only in RUN and SHALL be held at 0 otherwise.
REQ-010 FSM transitions SHALL be:
- IDLE to WAIT_FILL when enable=1.
- WAIT_FILL to RUN when fifo_empty=0.
- WAIT_FILL to IDLE when enable=0.
- RUN to IDLE only at the frame wrap (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1) while enable=0, so a frame is never truncated.
REQ-011 A position SHALL be active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-012 fifo_rd_en SHALL be combinational: state==RUN and active and not fifo_empty.
REQ-013 The sync and pixel pipeline SHALL have two stages.
- Stage 1 registers active, a popped flag (equal to fifo_rd_en), hsync and vsync.
- hsync in stage 1 is low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync is decoded the same way from v_cnt.
- Stage 2 registers all outputs.
- Total latency from counter position to outputs SHALL be exactly 2 clocks.
REQ-014 Stage-2 colour SHALL be:
- fifo_q, if stage-1 active and popped;
- UNDERFLOW_COLOR, if stage-1 active and not popped;
- 0, if not active.
REQ-015 An active position with fifo_empty=1 in RUN SHALL cause no pop.
- The pixel is dropped; there is no stall and the timing is unaffected.
- underflow SHALL be set.
REQ-016 underflow SHALL clear only on reset.
REQ-017 frame_start SHALL pulse for exactly one clock, coincident with output pixel (0,0).
REQ-018 Outside RUN, outputs SHALL be: hsync=1, vsync=1, blank_n=0, rgb=0, fifo_rd_en=0.

Reset
REQ-019 Reset SHALL asynchronously set:
- state to IDLE and both counters to 0;
- all pipeline registers cleared;
- hsync=1, vsync=1, blank_n=0, r=g=b=0, frame_start=0, underflow=0, fifo_rd_en=0.
REQ-020 Reset asserted mid-frame SHALL abort the frame immediately. After release, a fresh WAIT_FILL is required before streaming resumes.

Configuration
REQ-021 With VPU_UNDERFLOW_CNT_EN defined, the block SHALL add an output underflow_count (16 bits).
- It counts underflowed pixels and saturates at 16'hFFFF.
- It is cleared only by reset.
REQ-022 Without VPU_UNDERFLOW_CNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-023 A shared package vpu_pkg SHALL hold:
- the FSM state typedef;
- the 640x480 timing constants;
- the RGB888 pixel typedef.
REQ-024 Counter and sync decode SHALL live in one sub-module, vga_timing_gen, which outputs h_cnt, v_cnt, active, hsync_pre and vsync_pre, gated by a run input.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Reset mid-line -> all outputs reach their reset values asynchronously, before the next clk edge.
- enable=1 with fifo_empty=1 held for 1000 clocks -> state remains WAIT_FILL, fifo_rd_en=0, hsync=1.
- FIFO model pre-loaded with 0x112233 -> the first pixel after frame_start is r=0x11, g=0x22, b=0x33; blank_n stays high for 640 clocks per line; hsync is low for 96 clocks, starting 656 clocks after blank_n rises; the line period is 800 clocks.
- A full frame with data always available -> exactly 307200 fifo_rd_en pulses, 525 hsync pulses, 1 vsync pulse of 1600 clocks, and underflow=0.
- fifo_empty forced high for pixels 100..109 of line 5 -> those 10 pixels are 0xFF00FF with no pops; underflow=1; underflow_count=10 when the macro is defined; the timing is unchanged.
- enable dropped at line 200 -> the frame completes through v_cnt=524, then state=IDLE and hsync stays 1.
